// File: rtl/rca_seq_ctrl.sv
// Word-serial add/subtract: one CHUNK-bit ripple adder swept over WIDTH/CHUNK cycles, carry registered between slices.
// Latency NCHUNK cycles accept-to-valid; in_ready only in IDLE, result held in DONE until out_ready.

module rca #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout
);

  logic [CHUNK:0] c;

  always_comb begin
    c    = '0;
    sum  = '0;
    c[0] = cin;
    for (int i = 0; i < CHUNK; i++) begin
      sum[i]   = a[i] ^ b[i] ^ c[i];
      c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign cout = c[CHUNK];

endmodule

module rca_seq_ctrl #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             busy
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } opnd_t;

  state_t           state;
  state_t           state_nxt;
  opnd_t            opnd;
  logic             carry_reg;
  logic [IDXW-1:0]  idx;
  logic             last;
  logic [CHUNK-1:0] a_sl;
  logic [CHUNK-1:0] b_sl;
  logic [CHUNK-1:0] rca_sum;
  logic             rca_cout;

  assign last = (idx == LAST_IDX);
  assign a_sl = opnd.a[idx*CHUNK +: CHUNK];
  assign b_sl = opnd.b[idx*CHUNK +: CHUNK];

  rca #(.CHUNK(CHUNK)) u_rca (
    .a    (a_sl),
    .b    (b_sl),
    .cin  (carry_reg),
    .sum  (rca_sum),
    .cout (rca_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)  state_nxt = RUN;
      RUN:     if (last)      state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Subtract is folded in at accept time: B is stored inverted and the carry seeded with 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opnd      <= '0;
      carry_reg <= 1'b0;
      idx       <= '0;
      out_sum   <= '0;
      out_cout  <= 1'b0;
      out_ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            opnd.a    <= in_a;
            opnd.b    <= in_b ^ {WIDTH{in_sub}};
            carry_reg <= in_sub;
            idx       <= '0;
          end
        end
        RUN: begin
          out_sum[idx*CHUNK +: CHUNK] <= rca_sum;
          carry_reg                   <= rca_cout;
          if (last) begin
            out_cout <= rca_cout;
            out_ovf  <= (opnd.a[WIDTH-1] == opnd.b[WIDTH-1]) &
                        (rca_sum[CHUNK-1] != opnd.a[WIDTH-1]);
            idx      <= '0;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state == RUN) || (state == DONE);

endmodule

// File: tb/tb_rca_seq_ctrl.sv
// Scoreboard bench for rca_seq_ctrl: a 32/8 instance and an 8/8 (single-slice) instance.

module tb_rca_seq_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   rmode = 0;  // 0 random out_ready, 1 held low, 2 held high

  typedef struct {
    logic [31:0] sum;
    logic        c;
    logic        v;
    int          acc;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  logic        in_valid0 = 1'b0, in_ready0, in_sub0 = 1'b0;
  logic [31:0] in_a0 = '0, in_b0 = '0, out_sum0;
  logic        out_valid0, out_ready0 = 1'b0, out_cout0, out_ovf0, busy0;

  logic        in_valid1 = 1'b0, in_ready1, in_sub1 = 1'b0;
  logic [7:0]  in_a1 = '0, in_b1 = '0, out_sum1;
  logic        out_valid1, out_ready1 = 1'b0, out_cout1, out_ovf1, busy1;

  rca_seq_ctrl #(.WIDTH(32), .CHUNK(8)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid0), .in_ready(in_ready0),
    .in_a(in_a0), .in_b(in_b0), .in_sub(in_sub0),
    .out_valid(out_valid0), .out_ready(out_ready0),
    .out_sum(out_sum0), .out_cout(out_cout0), .out_ovf(out_ovf0),
    .busy(busy0)
  );

  rca_seq_ctrl #(.WIDTH(8), .CHUNK(8)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid1), .in_ready(in_ready1),
    .in_a(in_a1), .in_b(in_b1), .in_sub(in_sub1),
    .out_valid(out_valid1), .out_ready(out_ready1),
    .out_sum(out_sum1), .out_cout(out_cout1), .out_ovf(out_ovf1),
    .busy(busy1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #2;
    out_ready0 = (rmode == 2) ? 1'b1 : (rmode == 1) ? 1'b0 : 1'($urandom);
    out_ready1 = (rmode == 2) ? 1'b1 : 1'($urandom);
  end

  task automatic chk(input string name, input logic ok, input string detail);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: %s", name, detail);
    end
  endtask

  // Reference: signed/unsigned integer arithmetic on w-bit operands.
  function automatic void model(input int w, input logic [31:0] a, input logic [31:0] b,
                                input logic s, output logic [31:0] sum,
                                output logic c, output logic v);
    longint ua, ub, md, sa, sb, r;
    ua = 0; ub = 0;
    ua[31:0] = a;
    ub[31:0] = b;
    md = longint'(1) << w;
    sa = a[w-1] ? ua - md : ua;
    sb = b[w-1] ? ub - md : ub;
    r  = s ? sa - sb : sa + sb;
    v  = (r >= md / 2) || (r < -(md / 2));
    r  = s ? ua - ub : ua + ub;
    c  = s ? (ua >= ub) : (r >= md);
    r  = r % md;
    if (r < 0) r = r + md;
    sum = 32'(r);
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h7FFF_FFFF;
      3:       return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  task automatic send0(input logic [31:0] a, input logic [31:0] b, input logic s);
    exp_t e;
    int   n = 0;
    @(negedge clk);
    in_a0 = a; in_b0 = b; in_sub0 = s; in_valid0 = 1'b1;
    while (!in_ready0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready0) begin
      chk("send0_timeout", 1'b0, "in_ready never rose within 200 cycles");
      in_valid0 = 1'b0;
      return;
    end
    model(32, a, b, s, e.sum, e.c, e.v);
    e.acc = cyc + 1;
    q0.push_back(e);
    @(negedge clk);
    in_valid0 = 1'b0; in_a0 = $urandom; in_b0 = $urandom; in_sub0 = 1'($urandom);
  endtask

  task automatic send1(input logic [7:0] a, input logic [7:0] b, input logic s);
    exp_t e;
    int   n = 0;
    @(negedge clk);
    in_a1 = a; in_b1 = b; in_sub1 = s; in_valid1 = 1'b1;
    while (!in_ready1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready1) begin
      chk("send1_timeout", 1'b0, "in_ready never rose within 200 cycles");
      in_valid1 = 1'b0;
      return;
    end
    model(8, {24'h0, a}, {24'h0, b}, s, e.sum, e.c, e.v);
    e.acc = cyc + 1;
    q1.push_back(e);
    @(negedge clk);
    in_valid1 = 1'b0; in_a1 = 8'($urandom); in_b1 = 8'($urandom); in_sub1 = 1'($urandom);
  endtask

  task automatic drain();
    int n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("drain", q0.size() == 0 && q1.size() == 0,
        $sformatf("pending q0=%0d q1=%0d, required 0", q0.size(), q1.size()));
  endtask

  // Monitor for the 32-bit instance.
  logic        pv0 = 1'b0, pr0 = 1'b0, hc0, hv0;
  logic [31:0] hs0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      pv0 = 1'b0;
    end else begin
      if (out_valid0) begin
        if (!pv0) begin
          if (q0.size() == 0) chk("spurious0", 1'b0, "out_valid with nothing outstanding");
          else chk("latency0", cyc == q0[0].acc + 4,
                   $sformatf("valid at cycle %0d, required %0d", cyc, q0[0].acc + 4));
        end else if (!pr0) begin
          chk("stable0", out_sum0 == hs0 && out_cout0 == hc0 && out_ovf0 == hv0,
              $sformatf("sum=%h c=%b v=%b, required %h %b %b", out_sum0, out_cout0, out_ovf0, hs0, hc0, hv0));
        end
        chk("done_flags0", !in_ready0 && busy0,
            $sformatf("in_ready=%b busy=%b, required 0 1", in_ready0, busy0));
        if (out_ready0 && q0.size() != 0) begin
          e = q0.pop_front();
          chk("result0", out_sum0 == e.sum && out_cout0 == e.c && out_ovf0 == e.v,
              $sformatf("sum=%h c=%b v=%b, required %h %b %b", out_sum0, out_cout0, out_ovf0, e.sum, e.c, e.v));
        end
      end
      pv0 = out_valid0; pr0 = out_ready0;
      hs0 = out_sum0; hc0 = out_cout0; hv0 = out_ovf0;
    end
  end

  // Monitor for the single-slice instance.
  logic pv1 = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      pv1 = 1'b0;
    end else begin
      if (out_valid1) begin
        if (!pv1) begin
          if (q1.size() == 0) chk("spurious1", 1'b0, "out_valid with nothing outstanding");
          else chk("latency1", cyc == q1[0].acc + 1,
                   $sformatf("valid at cycle %0d, required %0d", cyc, q1[0].acc + 1));
        end
        chk("done_flags1", !in_ready1 && busy1,
            $sformatf("in_ready=%b busy=%b, required 0 1", in_ready1, busy1));
        if (out_ready1 && q1.size() != 0) begin
          e = q1.pop_front();
          chk("result1", out_sum1 == e.sum[7:0] && out_cout1 == e.c && out_ovf1 == e.v,
              $sformatf("sum=%h c=%b v=%b, required %h %b %b", out_sum1, out_cout1, out_ovf1, e.sum[7:0], e.c, e.v));
        end
      end
      pv1 = out_valid1;
    end
  end

  initial begin
    int   n;
    logic seen;
    #12;
    chk("reset0", in_ready0 && !out_valid0 && !busy0 && out_sum0 == 0 && !out_cout0 && !out_ovf0,
        $sformatf("rdy=%b vld=%b busy=%b sum=%h c=%b v=%b", in_ready0, out_valid0, busy0, out_sum0, out_cout0, out_ovf0));
    chk("reset1", in_ready1 && !out_valid1 && !busy1 && out_sum1 == 0 && !out_cout1 && !out_ovf1,
        $sformatf("rdy=%b vld=%b busy=%b sum=%h", in_ready1, out_valid1, busy1, out_sum1));
    @(negedge clk);
    rst_n = 1'b1;

    rmode = 2;
    send0(32'h00FF_FFFF, 32'h0000_0001, 1'b0);
    send0(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    send0(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
    send0(32'h0000_0005, 32'h0000_0007, 1'b1);
    send0(32'h8000_0000, 32'h0000_0001, 1'b1);
    send0(32'h1234_5678, 32'h0000_0000, 1'b1);
    drain();

    rmode = 0;
    for (int i = 0; i < 40; i++) begin
      send0(pick(), pick(), 1'($urandom));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    drain();

    // Backpressure: second request waits while the first result is held.
    rmode = 1;
    send0(32'hDEAD_BEEF, 32'h0123_4567, 1'b0);
    fork
      send0(32'h0000_0010, 32'h0000_0020, 1'b1);
    join_none
    n = 0;
    while (!out_valid0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("bp_valid", out_valid0, "out_valid never rose under backpressure");
    repeat (10) begin
      @(negedge clk);
      chk("bp_in_ready", !in_ready0 && out_valid0,
          $sformatf("in_ready=%b out_valid=%b, required 0 1", in_ready0, out_valid0));
    end
    rmode = 2;
    @(posedge clk);
    #3;
    @(posedge clk);
    @(negedge clk);
    chk("bp_release", in_ready0 && !out_valid0,
        $sformatf("in_ready=%b out_valid=%b, required 1 0", in_ready0, out_valid0));
    @(negedge clk);
    drain();

    // Abort in the middle of RUN.
    send0(32'hA5A5_A5A5, 32'h5A5A_5A5A, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("abort_busy", busy0 && !out_valid0, $sformatf("busy=%b vld=%b, required 1 0", busy0, out_valid0));
    #1;
    rst_n = 1'b0;
    q0.delete();
    #1;
    chk("abort_reset", in_ready0 && !out_valid0 && !busy0 && out_sum0 == 0 && !out_cout0 && !out_ovf0,
        $sformatf("rdy=%b vld=%b busy=%b sum=%h c=%b v=%b", in_ready0, out_valid0, busy0, out_sum0, out_cout0, out_ovf0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      seen = seen | out_valid0;
    end
    chk("abort_no_valid", !seen, "out_valid appeared after abort");
    send0(32'h0000_00FF, 32'h0000_0001, 1'b0);
    drain();

    // Single-slice build.
    send1(8'h80, 8'h80, 1'b0);
    send1(8'h00, 8'h01, 1'b1);
    send1(8'h7F, 8'h01, 1'b0);
    rmode = 0;
    for (int i = 0; i < 20; i++) begin
      send1(8'($urandom), 8'($urandom), 1'($urandom));
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
